// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a byte FIFO with a valid/ready input.
// Frames are sent LSB-first, back-to-back while the FIFO holds data.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DEPTH        = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     fpga_tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      mem_q [DEPTH];

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            bit_end;

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign in_ready   = !full;
    assign push       = in_valid & in_ready;
    assign bit_end    = (baud_q == BAUD_MAX);
    assign fpga_tx    = tx_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q != IDLE) | !empty;

    // Frame sequencer: next state, baud/bit counters, shift register and line level.
    // In IDLE and at the end of STOP the head byte is popped straight into the
    // shifter so consecutive frames have no idle gap.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (idx_q == STOP_LAST) begin
                        idx_d = 3'd0;
                        if (!empty) begin
                            pop     = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            tx_d    = 1'b0;
                            state_d = START;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping: pointers, occupancy and sticky overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (in_valid & !in_ready);
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset aborts any frame and discards buffered bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            idx_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
